// File: rtl/sent_pkg.sv
// SENT parameter frame constants, field limits and shared types.
// Shared by the parameter parser and its field validator.
package sent_pkg;

  localparam logic [3:0] SENT_ERR_NONE  = 4'd0;
  localparam logic [3:0] SENT_ERR_CHAN  = 4'd1;
  localparam logic [3:0] SENT_ERR_TICK  = 4'd2;
  localparam logic [3:0] SENT_ERR_LOW   = 4'd3;
  localparam logic [3:0] SENT_ERR_PMODE = 4'd4;
  localparam logic [3:0] SENT_ERR_PLEN  = 4'd5;
  localparam logic [3:0] SENT_ERR_CRC   = 4'd6;
  localparam logic [3:0] SENT_ERR_DLEN  = 4'd7;
  localparam logic [3:0] SENT_ERR_LEN   = 4'd8;

  localparam logic [7:0] SENT_PAUSE_NONE     = 8'd0;
  localparam logic [7:0] SENT_PAUSE_FIXED    = 8'd1;
  localparam logic [7:0] SENT_PAUSE_ADAPTIVE = 8'd2;

  localparam logic [7:0]  SENT_TICK_US_MIN   = 8'd3;
  localparam logic [7:0]  SENT_TICK_US_MAX   = 8'd90;
  localparam logic [7:0]  SENT_LOW_TICKS_MIN = 8'd4;
  localparam logic [15:0] SENT_PLEN_MIN      = 16'd12;
  localparam logic [15:0] SENT_PLEN_MAX      = 16'd768;
  localparam logic [7:0]  SENT_CRC_MAX       = 8'd1;
  localparam logic [7:0]  SENT_DLEN_MIN      = 8'd1;
  localparam logic [7:0]  SENT_DLEN_MAX      = 8'd6;

  localparam logic [2:0] SENT_WORD_CH     = 3'd0;
  localparam logic [2:0] SENT_WORD_TIMING = 3'd1;
  localparam logic [2:0] SENT_WORD_FMT    = 3'd2;
  localparam logic [2:0] SENT_WORD_DATA   = 3'd3;
  localparam logic [2:0] SENT_WORD_SAT    = 3'd4;

  typedef struct packed {
    logic [7:0]  channel;
    logic [7:0]  tick_us;
    logic [7:0]  low_ticks;
    logic [7:0]  pause_mode;
    logic [15:0] pause_len;
    logic [7:0]  crc_mode;
    logic [3:0]  status;
    logic [7:0]  data_len;
    logic [23:0] data;
  } sent_fields_t;

  typedef struct packed {
    logic [7:0]  channel;
    logic [7:0]  low_ticks;
    logic [1:0]  pause_mode;
    logic [9:0]  pause_len;
    logic        crc_mode;
    logic [3:0]  status;
    logic [2:0]  data_len;
    logic [23:0] data;
  } sent_cfg_t;

  function automatic logic [23:0] sent_data_mask(input logic [7:0] len);
    logic [23:0] m;
    case (len)
      8'd1:    m = 24'hF00000;
      8'd2:    m = 24'hFF0000;
      8'd3:    m = 24'hFFF000;
      8'd4:    m = 24'hFFFF00;
      8'd5:    m = 24'hFFFFF0;
      default: m = 24'hFFFFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sent_param_check.sv
// Combinational SENT parameter validator.
// Returns the lowest failing cause; a bad frame length overrides all.
module sent_param_check
  import sent_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic [7:0]  channel,
  input  logic [7:0]  tick_us,
  input  logic [7:0]  low_ticks,
  input  logic [7:0]  pause_mode,
  input  logic [15:0] pause_len,
  input  logic [7:0]  crc_mode,
  input  logic [7:0]  data_len,
  input  logic        len_ok,
  output logic [3:0]  err_code
);

  localparam logic [8:0] NUM_CH_W = 9'(NUM_CH);

  logic plen_bad;

  always_comb begin
    plen_bad = (pause_len < SENT_PLEN_MIN) ||
               (pause_len > SENT_PLEN_MAX);
    err_code = SENT_ERR_NONE;
    if (!len_ok)
      err_code = SENT_ERR_LEN;
    else if ({1'b0, channel} >= NUM_CH_W)
      err_code = SENT_ERR_CHAN;
    else if ((tick_us < SENT_TICK_US_MIN) ||
             (tick_us > SENT_TICK_US_MAX))
      err_code = SENT_ERR_TICK;
    else if (low_ticks < SENT_LOW_TICKS_MIN)
      err_code = SENT_ERR_LOW;
    else if (pause_mode > SENT_PAUSE_ADAPTIVE)
      err_code = SENT_ERR_PMODE;
    else if ((pause_mode != SENT_PAUSE_NONE) && plen_bad)
      err_code = SENT_ERR_PLEN;
    else if (crc_mode > SENT_CRC_MAX)
      err_code = SENT_ERR_CRC;
    else if ((data_len < SENT_DLEN_MIN) ||
             (data_len > SENT_DLEN_MAX))
      err_code = SENT_ERR_DLEN;
  end

endmodule

// File: rtl/sent_param_parser.sv
// Multi-channel SENT parameter frame parser: capture, validate,
// convert tick length to clock cycles, emit config or error strobe.
module sent_param_parser
  import sent_pkg::*;
#(
  parameter int ID_SENT_PARAM = 2,
  parameter int CLK_FREQ      = 100000000,
  parameter int NUM_CH        = 8,
  parameter int TICK_CNT_W    = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           rx_axis_udp_tdata,
  input  logic                  rx_axis_udp_tvalid,
  input  logic                  rx_axis_udp_tlast,
  input  logic [7:0]            rx_axis_udp_tuser,
  output logic                  cfg_vld,
  output logic [7:0]            cfg_channel,
  output logic [TICK_CNT_W-1:0] cfg_tick_cycles,
  output logic [7:0]            cfg_low_ticks,
  output logic [1:0]            cfg_pause_mode,
  output logic [9:0]            cfg_pause_len,
  output logic                  cfg_crc_mode,
  output logic [3:0]            cfg_status,
  output logic [2:0]            cfg_data_len,
  output logic [23:0]           cfg_data,
  output logic                  cfg_err,
  output logic [3:0]            cfg_err_code,
  output logic [15:0]           cnt_ok,
  output logic [15:0]           cnt_err
);

  localparam logic [7:0] ID_W = 8'(ID_SENT_PARAM);
  localparam logic [TICK_CNT_W-1:0] MULT_W =
    TICK_CNT_W'(CLK_FREQ / 1000000);

  // input register
  logic        in_vld_q, in_vld_d;
  logic        in_last_q, in_last_d;
  logic [31:0] in_data_q, in_data_d;
  logic [7:0]  in_user_q, in_user_d;

  always_comb begin
    in_vld_d  = rx_axis_udp_tvalid;
    in_last_d = rx_axis_udp_tlast;
    in_data_d = rx_axis_udp_tdata;
    in_user_d = rx_axis_udp_tuser;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_vld_q  <= 1'b0;
      in_last_q <= 1'b0;
      in_data_q <= '0;
      in_user_q <= '0;
    end else begin
      in_vld_q  <= in_vld_d;
      in_last_q <= in_last_d;
      in_data_q <= in_data_d;
      in_user_q <= in_user_d;
    end
  end

  // word counter, frame id and field holding registers
  logic [2:0]   wcnt_q, wcnt_d;
  logic         id_ok_q, id_ok_d;
  logic         done_q, done_d;
  logic         len_ok_q, len_ok_d;
  logic         id_now;
  sent_fields_t fld_q, fld_d;

  always_comb begin
    wcnt_d   = wcnt_q;
    id_ok_d  = id_ok_q;
    fld_d    = fld_q;
    done_d   = 1'b0;
    len_ok_d = len_ok_q;
    id_now   = (wcnt_q == SENT_WORD_CH) ?
               (in_user_q == ID_W) : id_ok_q;
    if (in_vld_q) begin
      id_ok_d  = id_now;
      done_d   = in_last_q && id_now;
      len_ok_d = (wcnt_q == SENT_WORD_DATA);
      if (in_last_q)
        wcnt_d = '0;
      else if (wcnt_q != SENT_WORD_SAT)
        wcnt_d = wcnt_q + 3'd1;
      unique case (wcnt_q)
        SENT_WORD_CH: fld_d.channel = in_data_q[7:0];
        SENT_WORD_TIMING: begin
          fld_d.tick_us         = in_data_q[31:24];
          fld_d.low_ticks       = in_data_q[23:16];
          fld_d.pause_mode      = in_data_q[15:8];
          fld_d.pause_len[15:8] = in_data_q[7:0];
        end
        SENT_WORD_FMT: begin
          fld_d.pause_len[7:0] = in_data_q[31:24];
          fld_d.crc_mode       = in_data_q[23:16];
          fld_d.status         = in_data_q[11:8];
          fld_d.data_len       = in_data_q[7:0];
        end
        SENT_WORD_DATA: fld_d.data = in_data_q[31:8];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt_q   <= '0;
      id_ok_q  <= 1'b0;
      done_q   <= 1'b0;
      len_ok_q <= 1'b0;
      fld_q    <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      id_ok_q  <= id_ok_d;
      done_q   <= done_d;
      len_ok_q <= len_ok_d;
      fld_q    <= fld_d;
    end
  end

  logic [3:0] chk_code;

  sent_param_check #(
    .NUM_CH (NUM_CH)
  ) u_check (
    .channel    (fld_q.channel),
    .tick_us    (fld_q.tick_us),
    .low_ticks  (fld_q.low_ticks),
    .pause_mode (fld_q.pause_mode),
    .pause_len  (fld_q.pause_len),
    .crc_mode   (fld_q.crc_mode),
    .data_len   (fld_q.data_len),
    .len_ok     (len_ok_q),
    .err_code   (chk_code)
  );

  // validate/multiply register
  logic                  v_vld_q, v_vld_d;
  logic [3:0]            v_code_q, v_code_d;
  logic [TICK_CNT_W-1:0] v_tick_q, v_tick_d;
  sent_cfg_t             v_cfg_q, v_cfg_d;

  always_comb begin
    v_vld_d            = done_q;
    v_code_d           = chk_code;
    v_tick_d           = TICK_CNT_W'(fld_q.tick_us) * MULT_W;
    v_cfg_d.channel    = fld_q.channel;
    v_cfg_d.low_ticks  = fld_q.low_ticks;
    v_cfg_d.pause_mode = fld_q.pause_mode[1:0];
    v_cfg_d.pause_len  = fld_q.pause_len[9:0];
    v_cfg_d.crc_mode   = fld_q.crc_mode[0];
    v_cfg_d.status     = fld_q.status;
    v_cfg_d.data_len   = fld_q.data_len[2:0];
    v_cfg_d.data       = fld_q.data &
                         sent_data_mask(fld_q.data_len);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_vld_q  <= 1'b0;
      v_code_q <= '0;
      v_tick_q <= '0;
      v_cfg_q  <= '0;
    end else begin
      v_vld_q  <= v_vld_d;
      v_code_q <= v_code_d;
      v_tick_q <= v_tick_d;
      v_cfg_q  <= v_cfg_d;
    end
  end

  // output register and status counters
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;
  logic [3:0]            code_q, code_d;
  logic [TICK_CNT_W-1:0] tick_q, tick_d;
  sent_cfg_t             cfg_q, cfg_d;
  logic [15:0]           ok_q, ok_d;
  logic [15:0]           bad_q, bad_d;
  logic                  accept;

  always_comb begin
    accept = v_vld_q && (v_code_q == SENT_ERR_NONE);
    vld_d  = accept;
    err_d  = v_vld_q && !accept;
    code_d = code_q;
    tick_d = tick_q;
    cfg_d  = cfg_q;
    ok_d   = ok_q;
    bad_d  = bad_q;
    if (accept) begin
      tick_d = v_tick_q;
      cfg_d  = v_cfg_q;
      if (ok_q != 16'hFFFF)
        ok_d = ok_q + 16'd1;
    end
    if (err_d) begin
      code_d = v_code_q;
      if (bad_q != 16'hFFFF)
        bad_d = bad_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      code_q <= '0;
      tick_q <= '0;
      cfg_q  <= '0;
      ok_q   <= '0;
      bad_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      code_q <= code_d;
      tick_q <= tick_d;
      cfg_q  <= cfg_d;
      ok_q   <= ok_d;
      bad_q  <= bad_d;
    end
  end

  assign cfg_vld         = vld_q;
  assign cfg_err         = err_q;
  assign cfg_err_code    = code_q;
  assign cfg_tick_cycles = tick_q;
  assign cfg_channel     = cfg_q.channel;
  assign cfg_low_ticks   = cfg_q.low_ticks;
  assign cfg_pause_mode  = cfg_q.pause_mode;
  assign cfg_pause_len   = cfg_q.pause_len;
  assign cfg_crc_mode    = cfg_q.crc_mode;
  assign cfg_status      = cfg_q.status;
  assign cfg_data_len    = cfg_q.data_len;
  assign cfg_data        = cfg_q.data;
  assign cnt_ok          = ok_q;
  assign cnt_err         = bad_q;

endmodule

// File: tb/tb_sent_param_parser.sv
// Directed, table-driven bench for sent_param_parser.
// Frames are built from field records; results come from hand values.
module tb_sent_param_parser;

  localparam logic [7:0] ID = 8'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [7:0]  tuser = '0;

  logic        cfg_vld, cfg_crc_mode, cfg_err;
  logic [7:0]  cfg_channel, cfg_low_ticks;
  logic [19:0] cfg_tick_cycles;
  logic [1:0]  cfg_pause_mode;
  logic [9:0]  cfg_pause_len;
  logic [3:0]  cfg_status, cfg_err_code;
  logic [2:0]  cfg_data_len;
  logic [23:0] cfg_data;
  logic [15:0] cnt_ok, cnt_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sent_param_parser dut (
    .clk                (clk),
    .rst                (rst),
    .rx_axis_udp_tdata  (tdata),
    .rx_axis_udp_tvalid (tvalid),
    .rx_axis_udp_tlast  (tlast),
    .rx_axis_udp_tuser  (tuser),
    .cfg_vld            (cfg_vld),
    .cfg_channel        (cfg_channel),
    .cfg_tick_cycles    (cfg_tick_cycles),
    .cfg_low_ticks      (cfg_low_ticks),
    .cfg_pause_mode     (cfg_pause_mode),
    .cfg_pause_len      (cfg_pause_len),
    .cfg_crc_mode       (cfg_crc_mode),
    .cfg_status         (cfg_status),
    .cfg_data_len       (cfg_data_len),
    .cfg_data           (cfg_data),
    .cfg_err            (cfg_err),
    .cfg_err_code       (cfg_err_code),
    .cnt_ok             (cnt_ok),
    .cnt_err            (cnt_err)
  );

  typedef struct {
    logic [7:0]  ch, tick, low, pm;
    logic [15:0] pl;
    logic [7:0]  crc;
    logic [3:0]  st;
    logic [7:0]  dlen;
    logic [23:0] data;
    int          nw;
    bit          ok;
    logic [3:0]  code;
    logic [19:0] tck;
    logic [23:0] dexp;
  } vec_t;

  typedef struct {
    int         at;
    bit         v;
    bit         e;
    logic [7:0] ch;
    logic [3:0] code;
  } ev_t;

  ev_t evq[$];
  int  n_chk = 0;
  int  n_fail = 0;

  // expected state of the config outputs and counters
  logic [7:0]  m_ch, m_low;
  logic [19:0] m_tick;
  logic [1:0]  m_pm;
  logic [9:0]  m_pl;
  logic        m_crc;
  logic [3:0]  m_st;
  logic [2:0]  m_dlen;
  logic [23:0] m_data;
  logic [15:0] m_ok, m_err;

  always @(negedge clk) begin
    if (rst && (cfg_vld || cfg_err))
      evq.push_back('{cyc, cfg_vld, cfg_err, cfg_channel, cfg_err_code});
    if (cfg_vld && cfg_err) begin
      n_fail++;
      $display("FAIL both_strobes: vld and err high at cycle %0d", cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input int ch, tick, low, pm, pl, crc, st, dlen,
    input logic [23:0] data, input int nw, input bit ok,
    input int code, input int tck, input logic [23:0] dexp);
    vec_t r;
    r.ch = 8'(ch); r.tick = 8'(tick); r.low = 8'(low); r.pm = 8'(pm);
    r.pl = 16'(pl); r.crc = 8'(crc); r.st = 4'(st); r.dlen = 8'(dlen);
    r.data = data; r.nw = nw; r.ok = ok; r.code = 4'(code);
    r.tck = 20'(tck); r.dexp = dexp;
    return r;
  endfunction

  function automatic logic [31:0] word_of(input vec_t r, input int i);
    case (i)
      0:       return {24'h0, r.ch};
      1:       return {r.tick, r.low, r.pm, r.pl[15:8]};
      2:       return {r.pl[7:0], r.crc, 4'h0, r.st, r.dlen};
      3:       return {r.data, 8'h00};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic send_frame(input vec_t r, input logic [7:0] id);
    for (int i = 0; i < r.nw; i++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = word_of(r, i);
      tlast  = (i == r.nw - 1);
      tuser  = id;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic collect(output ev_t ev, output bit got);
    got = 1'b0;
    ev  = '{-1, 1'b0, 1'b0, 8'h0, 4'h0};
    for (int k = 0; k < 12 && !got; k++) begin
      if (evq.size() > 0) begin
        ev  = evq.pop_front();
        got = 1'b1;
      end else begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic model_ok(input vec_t r);
    m_ch = r.ch; m_tick = r.tck; m_low = r.low; m_pm = r.pm[1:0];
    m_pl = r.pl[9:0]; m_crc = r.crc[0]; m_st = r.st;
    m_dlen = r.dlen[2:0]; m_data = r.dexp;
    m_ok = m_ok + 16'd1;
  endtask

  task automatic check_cfg(input string tag);
    chk({tag, ".channel"}, cfg_channel, m_ch);
    chk({tag, ".tick"}, cfg_tick_cycles, m_tick);
    chk({tag, ".low"}, cfg_low_ticks, m_low);
    chk({tag, ".pmode"}, cfg_pause_mode, m_pm);
    chk({tag, ".plen"}, cfg_pause_len, m_pl);
    chk({tag, ".crc"}, cfg_crc_mode, m_crc);
    chk({tag, ".status"}, cfg_status, m_st);
    chk({tag, ".dlen"}, cfg_data_len, m_dlen);
    chk({tag, ".data"}, cfg_data, m_data);
    chk({tag, ".cnt_ok"}, cnt_ok, m_ok);
    chk({tag, ".cnt_err"}, cnt_err, m_err);
  endtask

  task automatic model_clear();
    m_ch = '0; m_tick = '0; m_low = '0; m_pm = '0; m_pl = '0;
    m_crc = '0; m_st = '0; m_dlen = '0; m_data = '0;
    m_ok = '0; m_err = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vec[18];

  initial begin
    ev_t  ev, ev2;
    bit   got, got2;
    int   e0;
    vec_t va, vb, vr;

    vec[0]  = mk(3, 3, 5, 1, 100, 1, 10, 6, 24'hABCDEF, 4, 1, 0, 300,
                 24'hABCDEF);
    vec[1]  = mk(5, 90, 4, 0, 5, 0, 3, 2, 24'hABCDEF, 4, 1, 0, 9000,
                 24'hAB0000);
    vec[2]  = mk(8, 2, 5, 1, 100, 1, 0, 6, 24'h111111, 4, 0, 1, 0, 0);
    vec[3]  = mk(0, 2, 5, 1, 100, 1, 0, 6, 0, 4, 0, 2, 0, 0);
    vec[4]  = mk(0, 91, 5, 1, 100, 1, 0, 6, 0, 4, 0, 2, 0, 0);
    vec[5]  = mk(0, 50, 3, 1, 100, 1, 0, 6, 0, 4, 0, 3, 0, 0);
    vec[6]  = mk(0, 50, 4, 3, 100, 1, 0, 6, 0, 4, 0, 4, 0, 0);
    vec[7]  = mk(0, 50, 5, 2, 11, 1, 0, 6, 0, 4, 0, 5, 0, 0);
    vec[8]  = mk(0, 50, 5, 1, 769, 1, 0, 6, 0, 4, 0, 5, 0, 0);
    vec[9]  = mk(7, 90, 4, 2, 768, 1, 15, 1, 24'h123456, 4, 1, 0, 9000,
                 24'h100000);
    vec[10] = mk(0, 50, 5, 1, 100, 2, 0, 6, 0, 4, 0, 6, 0, 0);
    vec[11] = mk(0, 50, 5, 1, 100, 1, 0, 0, 0, 4, 0, 7, 0, 0);
    vec[12] = mk(0, 50, 5, 1, 100, 1, 0, 7, 0, 4, 0, 7, 0, 0);
    vec[13] = mk(1, 50, 5, 1, 100, 1, 0, 6, 0, 3, 0, 8, 0, 0);
    vec[14] = mk(1, 50, 5, 1, 100, 1, 0, 6, 0, 5, 0, 8, 0, 0);
    vec[15] = mk(1, 50, 5, 1, 100, 1, 0, 6, 0, 1, 0, 8, 0, 0);
    vec[16] = mk(9, 1, 0, 7, 0, 3, 0, 0, 0, 2, 0, 8, 0, 0);
    vec[17] = mk(2, 10, 6, 1, 12, 0, 5, 4, 24'h987654, 4, 1, 0, 1000,
                 24'h987600);

    model_clear();
    repeat (3) @(negedge clk);
    chk("rst.vld", cfg_vld, 0);
    chk("rst.err", cfg_err, 0);
    chk("rst.err_code", cfg_err_code, 0);
    check_cfg("rst");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      send_frame(vec[i], ID);
      e0 = cyc + 1;
      idle();
      collect(ev, got);
      chk($sformatf("v%0d.strobe", i), got, 1);
      if (got) begin
        chk($sformatf("v%0d.vld", i), ev.v, vec[i].ok);
        chk($sformatf("v%0d.err", i), ev.e, !vec[i].ok);
        chk($sformatf("v%0d.latency", i), ev.at - e0, 3);
        if (!vec[i].ok)
          chk($sformatf("v%0d.code", i), ev.code, vec[i].code);
      end
      if (vec[i].ok) model_ok(vec[i]);
      else m_err = m_err + 16'd1;
      check_cfg($sformatf("v%0d", i));
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d.extra", i), evq.size(), 0);
    end

    // zero-gap back-to-back accepted frames
    va = mk(4, 20, 5, 0, 0, 1, 1, 3, 24'h456789, 4, 1, 0, 2000,
            24'h456000);
    vb = mk(6, 30, 8, 1, 200, 0, 2, 5, 24'h13579B, 4, 1, 0, 3000,
            24'h135790);
    send_frame(va, ID);
    e0 = cyc + 1;
    send_frame(vb, ID);
    idle();
    collect(ev, got);
    collect(ev2, got2);
    chk("b2b.first_vld", got && ev.v, 1);
    chk("b2b.first_ch", ev.ch, 4);
    chk("b2b.first_lat", ev.at - e0, 3);
    chk("b2b.second_vld", got2 && ev2.v, 1);
    chk("b2b.second_ch", ev2.ch, 6);
    chk("b2b.spacing", ev2.at - ev.at, 4);
    model_ok(va);
    model_ok(vb);
    check_cfg("b2b");

    // foreign ID ignored, following frame still decoded
    va = mk(1, 40, 5, 0, 0, 1, 7, 6, 24'hFEDCBA, 4, 1, 0, 4000,
            24'hFEDCBA);
    send_frame(vec[0], 8'd5);
    send_frame(va, ID);
    idle();
    collect(ev, got);
    chk("id5.one_vld", got && ev.v, 1);
    chk("id5.ch", ev.ch, 1);
    repeat (6) @(negedge clk);
    chk("id5.no_extra", evq.size(), 0);
    model_ok(va);
    check_cfg("id5");

    // reset in the middle of a frame
    vr = mk(6, 5, 4, 0, 0, 0, 2, 6, 24'h0F0F0F, 4, 1, 0, 500,
            24'h0F0F0F);
    @(negedge clk); tvalid = 1'b1; tlast = 1'b0; tuser = ID;
    tdata = word_of(vec[0], 0);
    @(negedge clk); tdata = word_of(vec[0], 1);
    @(negedge clk); tdata = word_of(vec[0], 2); rst = 1'b0;
    @(negedge clk); tvalid = 1'b0;
    @(negedge clk);
    model_clear();
    check_cfg("midrst");
    rst = 1'b1;
    send_frame(vr, ID);
    e0 = cyc + 1;
    idle();
    collect(ev, got);
    chk("midrst.vld", got && ev.v, 1);
    chk("midrst.ch", ev.ch, 6);
    chk("midrst.lat", ev.at - e0, 3);
    repeat (6) @(negedge clk);
    chk("midrst.no_extra", evq.size(), 0);
    model_ok(vr);
    check_cfg("midrst_after");

    // error counter saturation with 1-word frames every cycle
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk);
      tvalid = 1'b1; tlast = 1'b1; tuser = ID; tdata = '0;
    end
    idle();
    repeat (6) @(negedge clk);
    chk("sat.strobes", evq.size(), 65534);
    chk("sat.pre", cnt_err, 16'hFFFE);
    evq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tvalid = 1'b1; tlast = 1'b1; tuser = ID; tdata = '0;
    end
    idle();
    repeat (6) @(negedge clk);
    chk("sat.strobes2", evq.size(), 3);
    chk("sat.hold", cnt_err, 16'hFFFF);
    chk("sat.cnt_ok", cnt_ok, m_ok);
    chk("sat.code", cfg_err_code, 8);
    evq.delete();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sent_param_parser.md
# sent_param_parser

Multi-channel SENT parameter parser: receives SENT parameter frames from the UDP receive stream, validates every field, converts the tick length from microseconds to clock cycles, and emits one per-channel configuration strobe, or an error strobe with a cause code. It sits between the UDP receive path and a bank of `NUM_CH` SENT transmit channels. It generalises the single-path parameter decoder with:

- a parameterised channel count;
- field range checking;
- frame-length checking;
- status counters.

## Interface

Parameters:

- `ID_SENT_PARAM`, 2: frame ID matched against `rx_axis_udp_tuser`.
- `CLK_FREQ`, 100000000: clock frequency in Hz. It must be a multiple of 1 000 000.
- `NUM_CH`, 8: number of channels, 1..256.
- `TICK_CNT_W`, 20: width of the tick-cycle output.

Ports (clock and reset first):

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `rx_axis_udp_tdata` in 32: frame word.
- `rx_axis_udp_tvalid` in 1: beat valid. There is no backpressure.
- `rx_axis_udp_tlast` in 1: last beat of the frame.
- `rx_axis_udp_tuser` in 8: frame ID.
- `cfg_vld` out 1: one-cycle strobe; the configuration outputs are valid.
- `cfg_channel` out 8: target channel.
- `cfg_tick_cycles` out `TICK_CNT_W`: tick length in clk cycles.
- `cfg_low_ticks` out 8: low-pulse ticks.
- `cfg_pause_mode` out 2: 0 = none, 1 = fixed, 2 = adaptive.
- `cfg_pause_len` out 10: pause length in ticks.
- `cfg_crc_mode` out 1: 0 = legacy, 1 = recommended.
- `cfg_status` out 4: status and communication nibble.
- `cfg_data_len` out 3: nibble count.
- `cfg_data` out 24: `{nibble1..nibble6}`, MSB-aligned.
- `cfg_err` out 1: one-cycle strobe; the frame was rejected.
- `cfg_err_code` out 4: rejection cause.
- `cnt_ok` out 16: accepted frames, saturating.
- `cnt_err` out 16: rejected frames, saturating.

## Operation

Frame format: exactly 4 words.

- Word 0: `[7:0]` channel.
- Word 1:
  - `[31:24]` tick_us.
  - `[23:16]` low_ticks.
  - `[15:8]` pause_mode.
  - `[7:0]` pause_len`[15:8]`.
- Word 2:
  - `[31:24]` pause_len`[7:0]`.
  - `[23:16]` crc_mode.
  - `[11:8]` status.
  - `[7:0]` data_len.
- Word 3: `[31:8]` data.

Frame handling:

- Input beats are registered once before any use.
- The frame ID is latched from the first beat only. A frame whose first-beat `tuser` differs from `ID_SENT_PARAM` is ignored entirely: no strobe and no counter update.
- The word counter clears on `tvalid && tlast` and otherwise increments on `tvalid`. It saturates at 4.
- Fields are captured into holding registers on their word index.

Validation at `tlast`, reported as the lowest failing code:

- 1: channel ≥ `NUM_CH`.
- 2: tick_us outside 3..90.
- 3: low_ticks < 4.
- 4: pause_mode > 2.
- 5: pause_mode ≠ 0 and pause_len outside 12..768. Pause length is ignored when pause_mode = 0.
- 6: crc_mode > 1.
- 7: data_len outside 1..6.
- 8: frame length ≠ 4 words. This code is checked first and overrides all field codes.

Outputs:

- Tick conversion: `cfg_tick_cycles` = tick_us × (`CLK_FREQ`/1 000 000), computed by a constant multiply with no rounding. With `CLK_FREQ` = 100 MHz and tick_us = 90, the result is 9000.
- Data masking: nibbles beyond data_len are forced to 0.
- An accepted frame produces a `cfg_vld` pulse and increments `cnt_ok`.
- A rejected frame produces a `cfg_err` pulse and increments `cnt_err`.
- Config outputs are updated only on an accepted frame and hold their values otherwise.

## Timing

Latency:

- `cfg_vld` or `cfg_err` asserts exactly 3 cycles after the edge that samples the `tlast` beat:
  - input register;
  - validate/multiply register;
  - output register.
- The counters update on the same edge as the strobe.

Back-to-back frames:

- Frames may arrive back-to-back with no gap, including 4-beat frames on consecutive cycles.
- The pipeline must not drop or merge them; one strobe is produced per frame.
- `cfg_vld` and `cfg_err` are never asserted in the same cycle.

Reset (`rst` = 0):

- All outputs clear to 0, including both counters.
- Any partial frame is discarded.
- After release, the next valid beat is word 0.

Boundary conditions:

- A `tlast` beat with word count 0 (a 1-word frame) produces error 8.
- A frame longer than 4 words produces error 8; the counter saturation keeps the count meaningful.
- Counters hold at 0xFFFF once saturated.

## Structure

- Package `sent_pkg` holds:
  - error-code constants `SENT_ERR_*`;
  - pause-mode constants;
  - field limits (3, 90, 4, 12, 768, 6);
  - word-index constants.
- Optional sub-module `sent_param_check`: purely combinational validator that returns the error code. Everything else stays in `sent_param_parser`.

## Test plan

1. Valid frame: channel 3, tick 3 µs, low ticks 5, pause mode 1, pause length 100, CRC mode 1, data length 6, data 0xABCDEF → `cfg_vld` on cycle 3; `cfg_tick_cycles` = 300; `cfg_data` = 0xABCDEF; `cnt_ok` = 1.
2. Data length 2 with data 0xABCDEF → `cfg_data` = 0xAB0000.
3. Channel 8 with `NUM_CH` = 8 and tick 2 → `cfg_err`, code 1 (lowest code wins); config outputs unchanged; `cnt_err` = 1.
4. 3-word frame, then a 5-word frame → two `cfg_err` pulses with code 8.
5. Two valid frames back-to-back with zero gap → two `cfg_vld` pulses 4 cycles apart with the correct channels. A frame with ID 5 → no response.
6. Reset asserted at word 2 of a frame, then a valid frame → only the second frame is reported. 65 536 error frames → `cnt_err` saturates at 0xFFFF.
